// File: rtl/trivium_ks_xor_if.sv
// Trivium keystream XOR stage: generator-side and byte-stream-side signal bundle.
// Optional ERR line present when TRIVIUM_KS_XOR_ERR_EN is defined.
interface trivium_ks_xor_if #(
  parameter int unsigned KS_W = 128,
  parameter int unsigned DW   = 8
);
  localparam int unsigned IV_W = 80;

  logic            START;
  logic [IV_W-1:0] IV_BASE;
  logic            KS_REQ;
  logic [IV_W-1:0] KS_IV;
  logic            KS_BSY;
  logic [KS_W-1:0] KS_IN;
  logic            KS_VLD;
  logic [DW-1:0]   DATA_IN;
  logic            DATA_IN_VLD;
  logic            DATA_IN_RDY;
  logic [DW-1:0]   DATA_OUT;
  logic            DATA_OUT_VLD;
  logic            DATA_OUT_RDY;
`ifdef TRIVIUM_KS_XOR_ERR_EN
  logic            ERR;
`endif

  // Design side
  modport slave (
    input  START, IV_BASE, KS_BSY, KS_IN, KS_VLD, DATA_IN, DATA_IN_VLD, DATA_OUT_RDY,
`ifdef TRIVIUM_KS_XOR_ERR_EN
    output ERR,
`endif
    output KS_REQ, KS_IV, DATA_IN_RDY, DATA_OUT, DATA_OUT_VLD
  );

  // Host / generator side
  modport master (
    output START, IV_BASE, KS_BSY, KS_IN, KS_VLD, DATA_IN, DATA_IN_VLD, DATA_OUT_RDY,
`ifdef TRIVIUM_KS_XOR_ERR_EN
    input  ERR,
`endif
    input  KS_REQ, KS_IV, DATA_IN_RDY, DATA_OUT, DATA_OUT_VLD
  );
endinterface

// File: rtl/trivium_ks_xor.sv
// Trivium keystream consumer: requests keystream blocks with a counting IV,
// buffers them, and XORs them byte-wise (MSB byte first) onto a data stream.
// Optional sticky ERR flag for unsolicited keystream: TRIVIUM_KS_XOR_ERR_EN.
module trivium_ks_xor #(
  parameter int unsigned KS_W     = 128,
  parameter int unsigned DW       = 8,
  parameter int unsigned KS_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  trivium_ks_xor_if.slave  bus
);
  localparam int unsigned IV_W = 80;
  localparam int unsigned NB   = KS_W / DW;
  localparam int unsigned BPW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DPW  = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(KS_DEPTH + 2);

  logic            run;
  logic            outstanding;
  logic            discard;
  logic            ks_req;
  logic [IV_W-1:0] ks_iv;
  logic [KS_W-1:0] ks_mem [KS_DEPTH];
  logic [DPW-1:0]  head;
  logic [DPW-1:0]  tail;
  logic [CW-1:0]   count;
  logic [BPW-1:0]  bptr;
  logic [DW-1:0]   data_out;
  logic            data_out_vld;
`ifdef TRIVIUM_KS_XOR_ERR_EN
  logic            err;
`endif

  logic [DW-1:0]   ks_bytes [NB];
  logic [DW-1:0]   ks_byte;
  logic            in_rdy;
  logic            in_hs;
  logic            push;
  logic            pop;
  logic            req_go;
  logic            pend_at_start;
  logic [CW-1:0]   pend;

  function automatic logic [DPW-1:0] ptr_next(input logic [DPW-1:0] p);
    return (p == DPW'(KS_DEPTH - 1)) ? '0 : p + DPW'(1);
  endfunction

  // Head block split into bytes, byte 0 taken from the MSBs
  for (genvar k = 0; k < NB; k++) begin : g_bytes
    assign ks_bytes[k] = ks_mem[head][KS_W-1-DW*k -: DW];
  end

  // Handshake, buffer push/pop and request decisions from registered state
  always_comb begin
    ks_byte       = ks_bytes[bptr];
    in_rdy        = run & (count != '0) & (~data_out_vld | bus.DATA_OUT_RDY);
    in_hs         = in_rdy & bus.DATA_IN_VLD;
    pop           = in_hs & (bptr == BPW'(NB - 1));
    push          = bus.KS_VLD & outstanding & ~discard;
    pend          = count + CW'(outstanding) + CW'(ks_req);
    req_go        = run & ~bus.KS_BSY & ~outstanding & ~ks_req & (pend < CW'(KS_DEPTH));
    // A pulse already on the wire or an unanswered request survives START and must be drained
    pend_at_start = ks_req | (outstanding & ~bus.KS_VLD);
  end

  // All state; START overrides every other same-cycle event
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run          <= 1'b0;
      outstanding  <= 1'b0;
      discard      <= 1'b0;
      ks_req       <= 1'b0;
      ks_iv        <= '0;
      ks_mem       <= '{default: '0};
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      bptr         <= '0;
      data_out     <= '0;
      data_out_vld <= 1'b0;
`ifdef TRIVIUM_KS_XOR_ERR_EN
      err          <= 1'b0;
`endif
    end else if (bus.START) begin
      run          <= 1'b1;
      ks_iv        <= bus.IV_BASE;
      ks_req       <= 1'b0;
      outstanding  <= pend_at_start;
      discard      <= pend_at_start;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      bptr         <= '0;
      data_out     <= '0;
      data_out_vld <= 1'b0;
`ifdef TRIVIUM_KS_XOR_ERR_EN
      err          <= 1'b0;
`endif
    end else begin
      ks_req <= req_go;
      if (ks_req) begin
        ks_iv       <= ks_iv + IV_W'(1);
        outstanding <= 1'b1;
      end
      if (bus.KS_VLD && outstanding) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
`ifdef TRIVIUM_KS_XOR_ERR_EN
      if (bus.KS_VLD && (!outstanding || ks_req)) err <= 1'b1;
`endif
      if (push) begin
        ks_mem[tail] <= bus.KS_IN;
        tail         <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_hs) begin
        bptr         <= pop ? '0 : bptr + BPW'(1);
        data_out     <= bus.DATA_IN ^ ks_byte;
        data_out_vld <= 1'b1;
      end else if (bus.DATA_OUT_RDY) begin
        data_out_vld <= 1'b0;
      end
    end
  end

  assign bus.KS_REQ       = ks_req;
  assign bus.KS_IV        = ks_iv;
  assign bus.DATA_IN_RDY  = in_rdy;
  assign bus.DATA_OUT     = data_out;
  assign bus.DATA_OUT_VLD = data_out_vld;
`ifdef TRIVIUM_KS_XOR_ERR_EN
  assign bus.ERR          = err;
`endif
endmodule

// File: tb/tb_trivium_ks_xor.sv
// Scoreboard bench for trivium_ks_xor: behavioural generator, keystream byte
// queue model, randomized byte stream. Honours TRIVIUM_KS_XOR_ERR_EN.
`timescale 1ns/1ps
module tb_trivium_ks_xor;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  trivium_ks_xor_if #(.KS_W(128), .DW(8)) bus ();
  trivium_ks_xor #(.KS_W(128), .DW(8), .KS_DEPTH(2)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int passes = 0;

  // Model state (written by the monitor only)
  bit          m_run  = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_disc = 1'b0;
  bit          m_err  = 1'b0;
  logic [79:0] m_iv   = '0;
  logic [7:0]  ks_q [$];
  logic [7:0]  exp_q [$];

  // Generator / stimulus controls
  int          gen_lat      = 3;
  bit          gen_lat_rand = 1'b0;
  int          gen_fixed_n  = 0;
  int          unsol_cnt    = 0;
  int          rdy_mode     = 0;
  int          wait_log [64];
  int          total_wait;
  localparam logic [127:0] FIXED_BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Behavioural generator: answers each request after a latency, plus on-demand unsolicited pulses
  initial begin
    int lat;
    int done = 0;
    int unsol_done = 0;
    logic [127:0] blk;
    bus.KS_BSY = 1'b0;
    bus.KS_VLD = 1'b0;
    bus.KS_IN  = '0;
    forever begin
      @(negedge CLK);
      if (bus.KS_REQ) begin
        lat = gen_lat_rand ? int'($urandom_range(30, 1)) : gen_lat;
        blk = (done < gen_fixed_n) ? FIXED_BLK : {$urandom, $urandom, $urandom, $urandom};
        done++;
        @(posedge CLK); #1 bus.KS_BSY = 1'b1;
        if (lat > 1) begin
          repeat (lat - 1) @(posedge CLK);
          #1;
        end
        bus.KS_VLD = 1'b1; bus.KS_IN = blk; bus.KS_BSY = 1'b0;
        @(posedge CLK); #1 bus.KS_VLD = 1'b0;
      end else if (unsol_done != unsol_cnt) begin
        unsol_done++;
        @(posedge CLK); #1 bus.KS_VLD = 1'b1; bus.KS_IN = {$urandom, $urandom, $urandom, $urandom};
        @(posedge CLK); #1 bus.KS_VLD = 1'b0;
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    bus.DATA_OUT_RDY = 1'b1;
    forever begin
      @(posedge CLK); #1;
      bus.DATA_OUT_RDY = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  end

  // Monitor + reference model: keystream is a FIFO of bytes in generation order
  initial begin
    bit exp_rdy;
    logic [127:0] blk;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        exp_rdy = m_run && (ks_q.size() != 0) && ((exp_q.size() == 0) || bus.DATA_OUT_RDY);
        chk("out_vld", bus.DATA_OUT_VLD, exp_q.size() != 0);
        if (bus.DATA_OUT_VLD && exp_q.size() != 0) begin
          chk("data_out", bus.DATA_OUT, exp_q[0]);
          if (bus.DATA_OUT_RDY) void'(exp_q.pop_front());
        end
        chk("in_rdy", bus.DATA_IN_RDY, exp_rdy);
        if (bus.DATA_IN_VLD && bus.DATA_IN_RDY && ks_q.size() != 0)
          exp_q.push_back(bus.DATA_IN ^ ks_q.pop_front());
`ifdef TRIVIUM_KS_XOR_ERR_EN
        chk("err", bus.ERR, m_err);
`endif
        if (bus.KS_VLD) begin
          if (m_pend) begin
            m_pend = 1'b0;
            if (m_disc) m_disc = 1'b0;
            else begin
              blk = bus.KS_IN;
              for (int k = 0; k < 16; k++) ks_q.push_back(8'(blk >> (120 - 8 * k)));
            end
          end else begin
            m_err = 1'b1;
          end
        end
        if (bus.KS_REQ) begin
          chk("ks_iv", bus.KS_IV, m_iv);
          chk("req_while_pending", m_pend, 1'b0);
          m_iv   = m_iv + 80'd1;
          m_pend = 1'b1;
          chk("depth_limit", ((ks_q.size() + 15) / 16 + 1) <= 2, 1'b1);
        end
        if (bus.START) begin
          m_run  = 1'b1;
          m_iv   = bus.IV_BASE;
          m_disc = m_pend;
          m_err  = 1'b0;
          ks_q.delete();
          exp_q.delete();
        end
      end
    end
  end

  task automatic start_pulse(input logic [79:0] iv);
    @(posedge CLK); #1 bus.IV_BASE = iv; bus.START = 1'b1;
    @(posedge CLK); #1 bus.START = 1'b0;
  endtask

  // Present n bytes; records per-byte stall cycles
  task automatic feed(input int n, input bit all_ff, input int gap_pct);
    int w;
    total_wait = 0;
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        bus.DATA_IN_VLD = 1'b0;
        @(posedge CLK); #1;
      end
      bus.DATA_IN     = all_ff ? 8'hFF : 8'($urandom);
      bus.DATA_IN_VLD = 1'b1;
      w = 0;
      forever begin
        @(negedge CLK);
        if (bus.DATA_IN_RDY) break;
        w++;
        if (w > 6000) break;
      end
      if (w > 6000) begin
        timeout("feed_rdy");
        bus.DATA_IN_VLD = 1'b0;
        return;
      end
      if (i < 64) wait_log[i] = w;
      total_wait += w;
      @(posedge CLK); #1;
    end
    bus.DATA_IN_VLD = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) return;
    end
    timeout("drain");
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge CLK);
      if (bus.KS_REQ) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    int s;
    RST = 1'b1;
    bus.START = 1'b0; bus.IV_BASE = '0; bus.DATA_IN = '0; bus.DATA_IN_VLD = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ks_req", bus.KS_REQ, 1'b0);
    chk("rst_ks_iv", bus.KS_IV, 80'd0);
    chk("rst_in_rdy", bus.DATA_IN_RDY, 1'b0);
    chk("rst_data_out", bus.DATA_OUT, 8'd0);
    chk("rst_out_vld", bus.DATA_OUT_VLD, 1'b0);
`ifdef TRIVIUM_KS_XOR_ERR_EN
    chk("rst_err", bus.ERR, 1'b0);
`endif
    @(posedge CLK); #1 RST = 1'b0;

    // Unsolicited keystream before any START: dropped (and flagged)
    unsol_cnt = 1;
    repeat (5) @(negedge CLK);
`ifdef TRIVIUM_KS_XOR_ERR_EN
    chk("err_sticky", bus.ERR, 1'b1);
`endif

    // Known block against 0xFF bytes at full rate
    gen_lat = 3; gen_fixed_n = 1;
    start_pulse(80'h0123);
    feed(16, 1'b1, 0);
    s = 0;
    for (int i = 1; i < 16; i++) s += wait_log[i];
    chk("ff_stream_stalls", s, 0);
`ifdef TRIVIUM_KS_XOR_ERR_EN
    chk("err_cleared", bus.ERR, 1'b0);
`endif

    // Downstream stall for 5 cycles mid-stream
    fork
      feed(12, 1'b0, 0);
      begin
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
          @(negedge CLK);
          if (bus.DATA_IN_VLD && bus.DATA_IN_RDY) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("hold_hs");
        rdy_mode = 2;
        @(posedge CLK);
        for (int t = 0; t < 5; t++) begin
          @(negedge CLK);
          chk("hold_in_rdy", bus.DATA_IN_RDY, 1'b0);
          chk("hold_out_vld", bus.DATA_OUT_VLD, 1'b1);
        end
        rdy_mode = 0;
      end
    join
    drain();

    // Randomized traffic, random latency and back-pressure
    rdy_mode = 1; gen_lat_rand = 1'b1;
    feed(64, 1'b0, 30);
    rdy_mode = 0;
    drain();

    // Slow generator, IV wrapping through 2^80
    gen_lat_rand = 1'b0; gen_lat = 1281;
    start_pulse(80'hFFFF_FFFF_FFFF_FFFF_FFFE);
    feed(40, 1'b0, 0);
    chk("empty_stalls_seen", total_wait > 2000, 1'b1);
    drain();

    // START while a request is outstanding: its block must be discarded
    gen_lat = 40;
    start_pulse(80'h5555);
    wait_req(ok);
    if (!ok) timeout("req_after_start");
    repeat (5) @(posedge CLK);
    #1;
    start_pulse(80'hABCD);
    wait_req(ok);
    if (ok) chk("iv_after_discard", bus.KS_IV, 80'hABCD);
    else timeout("req_after_discard");
    feed(16, 1'b0, 0);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
